// File: rtl/beehive_credit_pkg.sv
// rtl/beehive_credit_pkg.sv - shared defaults, flag struct and index-width helper for the credit tracker
package beehive_credit_pkg;

  localparam int DEFAULT_NUM_VC      = 2;
  localparam int DEFAULT_BUFFER_SIZE = 4;

  // Count-derived flags kept in registers so spc_avail needs no comparator
  typedef struct packed {
    logic is_one;
    logic is_two_plus;
  } credit_vc_flags_t;

  // Index width for n channels; a single channel still needs a 1-bit select
  function automatic int vc_index_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beehive_credit_vc_slice.sv
// rtl/beehive_credit_vc_slice.sv - one virtual channel: input registers, credit counter, flags, sticky errors
module beehive_credit_vc_slice
  import beehive_credit_pkg::*;
#(
  parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
  parameter int BUFFER_BITS = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   send,
  input  logic                   yummy,
  input  logic                   err_clear,
  output logic                   spc_avail,
  output logic [BUFFER_BITS-1:0] credit_count,
  output logic                   err_underflow,
  output logic                   err_overflow
);

  localparam logic [BUFFER_BITS-1:0] FULL  = BUFFER_BITS'(BUFFER_SIZE);
  localparam logic [BUFFER_BITS-1:0] ONE   = BUFFER_BITS'(1);
  localparam logic [BUFFER_BITS-1:0] EMPTY = '0;
  localparam credit_vc_flags_t RESET_FLAGS = '{
    is_one:      (BUFFER_SIZE == 1),
    is_two_plus: (BUFFER_SIZE >= 2)
  };

  logic                   yummy_f;
  logic                   send_f;
  logic [BUFFER_BITS-1:0] count;
  logic [BUFFER_BITS-1:0] count_next;
  credit_vc_flags_t       flags;
  credit_vc_flags_t       flags_next;
  logic                   up;
  logic                   down;
  logic                   set_under;
  logic                   set_over;

  assign up   = yummy_f & ~send_f;
  assign down = send_f & ~yummy_f;

  // Saturating next count, error events and the flags that will describe it
  always_comb begin
    count_next = count;
    set_under  = 1'b0;
    set_over   = 1'b0;
    if (up) begin
      if (count == FULL) set_over = 1'b1;
      else               count_next = count + ONE;
    end else if (down) begin
      if (count == EMPTY) set_under = 1'b1;
      else                count_next = count - ONE;
    end
    flags_next.is_one      = (count_next == ONE);
    flags_next.is_two_plus = (count_next > ONE);
  end

  // Input capture, committed count, flags and sticky errors (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yummy_f       <= 1'b0;
      send_f        <= 1'b0;
      count         <= FULL;
      flags         <= RESET_FLAGS;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      yummy_f       <= yummy;
      send_f        <= send;
      count         <= count_next;
      flags         <= flags_next;
      err_underflow <= set_under | (err_underflow & ~err_clear);
      err_overflow  <= set_over | (err_overflow & ~err_clear);
    end
  end

  // A pending return always frees a slot; a lone last credit is spoken for by a pending send
  assign spc_avail    = flags.is_two_plus | yummy_f | (flags.is_one & ~send_f);
  assign credit_count = count;

endmodule

// File: rtl/beehive_credit_tracker_mc.sv
// rtl/beehive_credit_tracker_mc.sv - multi-VC credit tracker for Beehive NoC senders
module beehive_credit_tracker_mc
  import beehive_credit_pkg::*;
#(
  parameter  int NUM_VC      = DEFAULT_NUM_VC,
  parameter  int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
  parameter  int BUFFER_BITS = $clog2(BUFFER_SIZE + 1),
  localparam int VC_W        = vc_index_w(NUM_VC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic [VC_W-1:0]               valid_vc,
  input  logic [NUM_VC-1:0]             yummy,
  input  logic                          err_clear,
  output logic [NUM_VC-1:0]             spc_avail,
  output logic [NUM_VC*BUFFER_BITS-1:0] credit_count,
  output logic [NUM_VC-1:0]             err_underflow,
  output logic [NUM_VC-1:0]             err_overflow
);

  logic [NUM_VC-1:0] send_vc;

  // One-hot send decode; an out-of-range channel index selects nothing
  always_comb begin
    send_vc = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      send_vc[i] = valid && (valid_vc == VC_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    beehive_credit_vc_slice #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .BUFFER_BITS (BUFFER_BITS)
    ) u_slice (
      .clk           (clk),
      .rst_n         (rst_n),
      .send          (send_vc[i]),
      .yummy         (yummy[i]),
      .err_clear     (err_clear),
      .spc_avail     (spc_avail[i]),
      .credit_count  (credit_count[i*BUFFER_BITS +: BUFFER_BITS]),
      .err_underflow (err_underflow[i]),
      .err_overflow  (err_overflow[i])
    );
  end

endmodule

// File: tb/tb_beehive_credit_tracker_mc.sv
// tb/tb_beehive_credit_tracker_mc.sv - self-checking bench for beehive_credit_tracker_mc
module tb_beehive_credit_tracker_mc;

  localparam int NV = 2;
  localparam int BS = 4;
  localparam int BB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic [0:0]    valid_vc = 1'b0;
  logic [NV-1:0] yummy = '0;
  logic          err_clear = 1'b0;
  logic [NV-1:0] spc_avail;
  logic [NV*BB-1:0] credit_count;
  logic [NV-1:0] err_underflow;
  logic [NV-1:0] err_overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: committed credits, what was presented last cycle, sticky errors
  int m_cnt [NV];
  bit m_ps  [NV];
  bit m_py  [NV];
  bit m_eu  [NV];
  bit m_eo  [NV];
  int held  [NV];

  beehive_credit_tracker_mc #(.NUM_VC(NV), .BUFFER_SIZE(BS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid         (valid),
    .valid_vc      (valid_vc),
    .yummy         (yummy),
    .err_clear     (err_clear),
    .spc_avail     (spc_avail),
    .credit_count  (credit_count),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model update: a lone send spends a credit, a lone return gives one back, both cancel
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NV; i++) begin
        m_cnt[i] = BS; m_ps[i] = 0; m_py[i] = 0; m_eu[i] = 0; m_eo[i] = 0;
      end
    end else begin
      for (int i = 0; i < NV; i++) begin
        bit su, so;
        su = 0; so = 0;
        if (m_ps[i] && !m_py[i]) begin
          if (m_cnt[i] == 0) su = 1; else m_cnt[i] = m_cnt[i] - 1;
        end else if (m_py[i] && !m_ps[i]) begin
          if (m_cnt[i] == BS) so = 1; else m_cnt[i] = m_cnt[i] + 1;
        end
        m_eu[i] = su ? 1'b1 : (err_clear ? 1'b0 : m_eu[i]);
        m_eo[i] = so ? 1'b1 : (err_clear ? 1'b0 : m_eo[i]);
        m_ps[i] = valid && (int'(valid_vc) == i);
        m_py[i] = yummy[i];
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      logic [NV-1:0] e_av, e_eu, e_eo;
      logic [NV*BB-1:0] e_cc;
      for (int i = 0; i < NV; i++) begin
        e_av[i] = m_py[i] || ((m_cnt[i] - int'(m_ps[i])) >= 1);
        e_cc[i*BB +: BB] = BB'(m_cnt[i]);
        e_eu[i] = m_eu[i];
        e_eo[i] = m_eo[i];
      end
      chk("cyc_spc_avail", 32'(spc_avail), 32'(e_av));
      chk("cyc_credit_count", 32'(credit_count), 32'(e_cc));
      chk("cyc_err_underflow", 32'(err_underflow), 32'(e_eu));
      chk("cyc_err_overflow", 32'(err_overflow), 32'(e_eo));
    end
  end

  task automatic cyc(input bit v, input bit vc, input logic [1:0] y, input bit clr);
    @(posedge clk);
    #2;
    valid = v; valid_vc = vc; yummy = y; err_clear = clr;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_spc_avail"}, 32'(spc_avail), 32'h3);
    chk({tag, "_credit_count"}, 32'(credit_count), 32'h24);
    chk({tag, "_err_underflow"}, 32'(err_underflow), 32'h0);
    chk({tag, "_err_overflow"}, 32'(err_overflow), 32'h0);
  endtask

  initial begin
    // Reset asserted between edges must take effect without a clock
    #12 rst_n = 1'b0;
    #1 reset_literals("reset");
    #15 rst_n = 1'b1;
    chk_en = 1'b1;

    // Drain VC0 in cycles 0-3
    for (int t = 0; t < 4; t++) cyc(1, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);                       // cycle 4
    @(negedge clk);
    chk("drain_avail0_c4", 32'(spc_avail[0]), 32'd0);
    chk("drain_avail1_c4", 32'(spc_avail[1]), 32'd1);
    cyc(0, 0, 2'b00, 0);                       // cycle 5
    @(negedge clk);
    chk("drain_cnt0_c5", 32'(credit_count[2:0]), 32'd0);
    chk("drain_cnt1_c5", 32'(credit_count[5:3]), 32'd4);

    // Refill from empty
    cyc(0, 0, 2'b01, 0);                       // cycle 6
    cyc(0, 0, 2'b00, 0);                       // cycle 7
    @(negedge clk);
    chk("refill_avail0_c7", 32'(spc_avail[0]), 32'd1);
    chk("refill_cnt0_c7", 32'(credit_count[2:0]), 32'd0);
    cyc(0, 0, 2'b00, 0);                       // cycle 8
    @(negedge clk);
    chk("refill_cnt0_c8", 32'(credit_count[2:0]), 32'd1);

    // Back to zero, then simultaneous send and return at zero
    cyc(1, 0, 2'b00, 0);                       // cycle 9
    cyc(0, 0, 2'b00, 0);                       // cycle 10
    cyc(0, 0, 2'b00, 0);                       // cycle 11
    @(negedge clk);
    chk("zero_cnt0_c11", 32'(credit_count[2:0]), 32'd0);
    for (int t = 0; t < 3; t++) cyc(1, 0, 2'b01, 0);
    cyc(0, 0, 2'b00, 0);                       // cycle 15
    cyc(0, 0, 2'b00, 0);                       // cycle 16
    @(negedge clk);
    chk("simul_cnt0", 32'(credit_count[2:0]), 32'd0);
    chk("simul_no_underflow", 32'(err_underflow[0]), 32'd0);

    // Underflow: send at zero with no return
    cyc(1, 0, 2'b00, 0);                       // cycle 17
    cyc(0, 0, 2'b00, 0);                       // cycle 18
    cyc(0, 0, 2'b00, 0);                       // cycle 19
    @(negedge clk);
    chk("underflow_set", 32'(err_underflow), 32'h1);
    chk("underflow_cnt0", 32'(credit_count[2:0]), 32'd0);

    // Overflow: return on full VC1
    cyc(0, 0, 2'b10, 0);                       // cycle 20
    cyc(0, 0, 2'b00, 0);                       // cycle 21
    cyc(0, 0, 2'b00, 0);                       // cycle 22
    @(negedge clk);
    chk("overflow_set", 32'(err_overflow), 32'h2);
    chk("overflow_cnt1", 32'(credit_count[5:3]), 32'd4);

    // Clear, then clear racing a fresh overflow
    cyc(0, 0, 2'b00, 1);                       // cycle 23
    cyc(0, 0, 2'b00, 0);                       // cycle 24
    @(negedge clk);
    chk("clear_underflow", 32'(err_underflow), 32'h0);
    chk("clear_overflow", 32'(err_overflow), 32'h0);
    cyc(0, 0, 2'b10, 0);                       // cycle 25
    cyc(0, 0, 2'b00, 1);                       // cycle 26
    cyc(0, 0, 2'b00, 0);                       // cycle 27
    @(negedge clk);
    chk("set_beats_clear", 32'(err_overflow), 32'h2);
    chk("clear_only_underflow", 32'(err_underflow), 32'h0);
    cyc(0, 0, 2'b00, 1);                       // cycle 28
    cyc(0, 0, 2'b00, 0);                       // cycle 29
    @(negedge clk);
    chk("reclear_overflow", 32'(err_overflow), 32'h0);

    // Clean start for the legal-credit random phase
    @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    for (int i = 0; i < NV; i++) held[i] = 0;

    for (int n = 0; n < 10000; n++) begin
      bit v, vc;
      logic [1:0] y;
      @(posedge clk);
      #2;
      y = 2'b00;
      for (int i = 0; i < NV; i++) begin
        if (held[i] > 0 && $urandom_range(1, 0) == 1) begin
          y[i] = 1'b1;
          held[i] = held[i] - 1;
        end
      end
      vc = 1'($urandom_range(1, 0));
      v = 1'b0;
      if ($urandom_range(3, 0) != 0 &&
          (m_cnt[vc] + int'(m_py[vc]) - int'(m_ps[vc])) >= 1) begin
        v = 1'b1;
        held[vc] = held[vc] + 1;
      end
      valid = v; valid_vc = vc; yummy = y; err_clear = 1'b0;
    end
    cyc(0, 0, 2'b00, 0);
    @(negedge clk);
    chk("random_no_underflow", 32'(err_underflow), 32'h0);
    chk("random_no_overflow", 32'(err_overflow), 32'h0);

    // Reset with a send already captured: it must be discarded
    cyc(1, 0, 2'b01, 0);
    @(posedge clk);
    #3;
    valid = 1'b0; yummy = 2'b00;
    rst_n = 1'b0;
    #1 reset_literals("midreset");
    #8 rst_n = 1'b1;
    cyc(0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);
    @(negedge clk);
    reset_literals("after_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beehive_credit_tracker_mc.md
# beehive_credit_tracker_mc

Multi-virtual-channel credit tracker for Beehive NoC senders. For each of `NUM_VC` downstream input buffers it counts the free slots, consumes a credit when the sender launches a flit on that channel, and returns a credit when the receiver pulses `yummy`. It sits beside each router or endpoint output port, in front of the flit mux, and drives per-channel `spc_avail` purely from registers. It adds configurable depth and channel count, a credit-count readout, and sticky over/underflow error flags.

## Interface
Parameters:
- `NUM_VC`, default 2: number of virtual channels (≥1).
- `BUFFER_SIZE`, default 4: downstream buffer depth per VC, i.e. initial credits (≥1).
- `BUFFER_BITS`, default `$clog2(BUFFER_SIZE+1)`: counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `valid` in 1: a flit is sent this cycle.
- `valid_vc` in `$clog2(NUM_VC)` (min 1): VC of the sent flit; ignored when `valid`=0.
- `yummy` in `NUM_VC`: per-VC credit return, one credit per set bit per cycle.
- `err_clear` in 1: synchronous clear of the sticky error flags.
- `spc_avail` out `NUM_VC`: sender may launch on VC i this cycle.
- `credit_count` out `NUM_VC*BUFFER_BITS`: committed count per VC; VC i occupies bits [i*BUFFER_BITS +: BUFFER_BITS].
- `err_underflow` out `NUM_VC`: sticky; a send was applied with no credit.
- `err_overflow` out `NUM_VC`: sticky; a credit was returned while the count was already full.

## Operation
- Inputs are registered first: `yummy_f[i]` and `send_f[i]` = `valid & (valid_vc==i)`. Only these registers drive the counters.
- Per VC: `up` = `yummy_f & ~send_f`; `down` = `send_f & ~yummy_f`. When both are set, the count holds.
- The next count is `count+1` on `up`, `count-1` on `down`, otherwise unchanged.
- Saturation:
  - `down` at count 0 holds at 0 and sets `err_underflow[i]`.
  - `up` at count `BUFFER_SIZE` holds and sets `err_overflow[i]`.
- Precomputed flags, registered from the next count: `is_one` (next count == 1) and `is_two_plus` (next count ≥ 2).
- `spc_avail[i]` = `is_two_plus | yummy_f | (is_one & ~send_f)`. This means effective credits (count + pending yummy − pending send) ≥ 1.
- No combinational path from any input to `spc_avail`.
- Errors:
  - Set has priority over `err_clear` in the same cycle.
  - `err_clear` otherwise zeroes both flag vectors.
  - Counting continues normally after an error.
- A `valid_vc` ≥ `NUM_VC` is dropped: no channel decrements.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - count = `BUFFER_SIZE` on all VCs.
  - `yummy_f` = 0, `send_f` = 0.
  - `is_one` = (`BUFFER_SIZE`==1), `is_two_plus` = (`BUFFER_SIZE`≥2).
  - `spc_avail` = all ones; `credit_count` = `BUFFER_SIZE` per VC; both error vectors = 0.
- Reset deasserting mid-traffic discards any in-flight `yummy_f`/`send_f`.
- `valid` in cycle t:
  - `send_f` is set in t+1, and `spc_avail` reflects the send in t+1.
  - `credit_count` decrements in t+2.
- `yummy` in cycle t: `spc_avail` can rise in t+1; `credit_count` increments in t+2.
- Simultaneous send and yummy on one VC: the count is unchanged, and no error is raised even at 0 or full.
- Channels are independent. Yummy on VC1 never affects VC0.

## Structure
- Package `beehive_credit_pkg` holds:
  - the default `NUM_VC`/`BUFFER_SIZE` localparams;
  - a `credit_vc_flags_t` struct {`is_one`, `is_two_plus`};
  - the `vc_index_w(n)` function (`$clog2` with a minimum of 1).
- Sub-module `beehive_credit_vc_slice` is one channel: input registers, counter, flags, errors. The top level generates `NUM_VC` slices and decodes `valid_vc` into the per-VC send bits.

## Test plan
All scenarios use `NUM_VC`=2, `BUFFER_SIZE`=4.
- Reset: assert `rst_n`=0 mid-clock → immediately `spc_avail`=2'b11, both counts 4, errors 0, with no clock edge required.
- Drain: `valid`, `valid_vc`=0 in cycles 0–3 → `spc_avail[0]`=0 from cycle 4, `credit_count[0]`=0 in cycle 5, `spc_avail[1]` stays 1 and `credit_count[1]` stays 4.
- Refill from empty: after the drain, `yummy`=2'b01 in cycle 6 → `spc_avail[0]`=1 in cycle 7, count 1 in cycle 8.
- Simultaneous events: at count 0 on VC0, drive `valid`/`valid_vc`=0 together with `yummy[0]` for 3 cycles → count stays 0, `err_underflow[0]`=0.
- Errors:
  - `yummy[1]` at count 4 → `err_overflow[1]`=1 two cycles later, count stays 4.
  - Drive `valid`/`valid_vc`=0 at count 0 with no `yummy` → `err_underflow[0]`=1.
  - `err_clear` → flags 0 the next cycle.
  - An error event in the same cycle as `err_clear` leaves the flag set.
- Randomised send/yummy under a legal-credit model for 10k cycles → `credit_count` matches the model, `spc_avail` is never 0 while the model has credit, and no error flags are raised.
